ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: prog_clk (clock) and prog_reset (reset); all state updates on rising prog_clk.
REQ-002 prog_clk  input  1  programming clock, same clock that drives the configuration chain flops.
REQ-003 prog_reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load session; honoured only in IDLE.
REQ-005 abort  input  1  terminates an active session.
REQ-006 chain_len  input  16  number of chain bits; sampled only on an accepted start.
REQ-007 cfg_data  input  8  next configuration byte, MSB shifted first.
REQ-008 cfg_valid  input  1  cfg_data valid.
REQ-009 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-010 ccff_head  output  1  serial data into the chain head.
REQ-011 ccff_shift_en  output  1  chain clock enable; the chain shifts on every prog_clk edge where this is high.
REQ-012 ccff_tail  input  1  serial data from the chain tail (old contents).
REQ-013 rb_data  output  8  readback byte of old chain contents, first bit out in MSB.
REQ-014 rb_valid  output  1  one-cycle strobe qualifying rb_data; no backpressure.
REQ-015 busy  output  1  high outside IDLE.
REQ-016 done  output  1  one-cycle pulse at normal session completion.
REQ-017 aborted  output  1  sticky; set by abort, cleared by the next accepted start.

Function
REQ-018 States SHALL be IDLE, LOAD and FIN.
REQ-019 IDLE + start: latch remaining = chain_len and clear aborted. Go to LOAD if chain_len != 0; otherwise go to FIN.
REQ-020 start in LOAD or FIN SHALL be ignored.
REQ-021 The loader SHALL hold an 8-bit shift buffer and a 4-bit buffered-bit count.
REQ-022 cfg_ready = LOAD && remaining > buffered-bit count && (count == 0 || (count == 1 && shifting this cycle)).
REQ-023 A handshake (cfg_valid && cfg_ready) SHALL load the buffer with min(8, remaining - bits still buffered after this cycle) valid bits, taken from the MSB of cfg_data; unused low bits are discarded.
REQ-024 ccff_shift_en = LOAD && count != 0; ccff_head = buffer MSB, combinationally.
REQ-025 On each shift edge: decrement remaining and count, shift the buffer left, and shift ccff_tail into the readback register.
REQ-026 No bubbles: with cfg_valid held high, ccff_shift_en SHALL remain high for chain_len consecutive cycles after the first accept.
REQ-027 cfg_valid low with an empty buffer SHALL stall with ccff_shift_en low; the chain holds its contents.
REQ-028 rb_valid SHALL pulse the cycle after the 8th readback bit of each byte is captured.
REQ-029 The final partial readback byte SHALL be left-justified and zero-padded, and emitted in FIN.
REQ-030 LOAD -> FIN the cycle after the last shift edge (remaining reaches 0).
REQ-031 FIN lasts one cycle: it pulses done (and rb_valid if a partial byte is pending), then returns to IDLE.
REQ-032 abort in LOAD or FIN SHALL, on that edge: go to IDLE, set aborted, drop ccff_shift_en and cfg_ready the same cycle, suppress done and pending rb_valid, and clear the buffer.
REQ-033 abort in IDLE SHALL be ignored.
REQ-034 abort and start in the same IDLE cycle: start wins.

Reset
REQ-035 prog_reset SHALL force: state IDLE; remaining, buffer, count and readback register = 0; cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done and aborted = 0.
REQ-036 prog_reset mid-session SHALL stop shifting the same cycle, with no done and no rb_valid.
REQ-037 prog_reset has priority over start and abort.

Structure
REQ-038 A shared package ccff_pkg SHALL hold the state enum, CCFF_LEN_W = 16 and CCFF_BYTE_W = 8.
REQ-039 The readback deserializer SHALL be one sub-module, ccff_rb_deser: serial in, byte out, plus a flush input.

Verification
REQ-040 chain_len = 16, bytes 0xA5 then 0x3C with cfg_valid held high, chain preloaded with 0xFFFF -> ccff_head sequence 1010010100111100 over 16 consecutive shift cycles; rb_data 0xFF, 0xFF; done the cycle after the 16th shift.
REQ-041 chain_len = 11, bytes 0xF0 then 0xE0 -> exactly 11 shifts, head 11110000111; the low 5 bits of the second byte are discarded; readback of the prior 3-bit remainder is left-justified (e.g. 0b101 -> 0xA0).
REQ-042 chain_len = 8, cfg_valid low for 5 cycles after the first byte is requested -> ccff_shift_en low for those 5 cycles, then 8 shifts; chain contents equal the byte.
REQ-043 chain_len = 0 -> busy for one cycle, done pulse, zero shift edges, no rb_valid.
REQ-044 abort after 5 of 16 shifts -> ccff_shift_en low the same cycle, aborted = 1, no done; the next start clears aborted.
REQ-045 prog_reset asserted mid-LOAD, and start pulsed while busy -> all outputs 0 the next cycle; the ignored start causes no change of chain_len.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
// State encoding, widths and small bit helpers.
package ccff_pkg;

    localparam int CCFF_LEN_W  = 16;
    localparam int CCFF_BYTE_W = 8;
    localparam int CCFF_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } ccff_state_e;

    // Left-justify the n low bits of sr (n = 1..7), zero padded.
    function automatic logic [CCFF_BYTE_W-1:0] ccff_ljust(
        input logic [CCFF_BYTE_W-1:0] sr,
        input logic [2:0]             n
    );
        return sr << (4'd8 - {1'b0, n});
    endfunction

    // Mask keeping the n most significant bits of a byte (n = 0..8).
    function automatic logic [CCFF_BYTE_W-1:0] ccff_msb_mask(
        input logic [CCFF_CNT_W-1:0] n
    );
        return 8'hFF << (4'd8 - n);
    endfunction

endpackage

// File: rtl/ccff_rb_deser.sv
// Readback deserializer: collects old chain bits MSB-first into bytes.
// Flush emits a pending partial byte left-justified; clear drops it.
module ccff_rb_deser
    import ccff_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_shift,
    input  logic                   i_din,
    input  logic                   i_flush,
    output logic [CCFF_BYTE_W-1:0] o_data,
    output logic                   o_valid
);

    logic [CCFF_BYTE_W-1:0] r_sr;
    logic [CCFF_BYTE_W-1:0] r_byte;
    logic [2:0]             r_n;
    logic                   r_vld;
    logic                   w_kill;
    logic                   w_part;

    assign w_kill = i_rst || i_clr;
    assign w_part = i_flush && (r_n != 3'd0);

    // Shift in tail bits; a full byte is latched and strobed next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr   <= '0;
            r_byte <= '0;
            r_n    <= '0;
            r_vld  <= 1'b0;
        end else if (i_clr) begin
            r_sr  <= '0;
            r_n   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (i_shift) begin
                r_sr <= {r_sr[CCFF_BYTE_W-2:0], i_din};
                r_n  <= r_n + 3'd1;
                if (r_n == 3'd7) begin
                    r_byte <= {r_sr[CCFF_BYTE_W-2:0], i_din};
                    r_vld  <= 1'b1;
                end
            end else if (i_flush) begin
                r_sr <= '0;
                r_n  <= '0;
            end
        end
    end

    // Partial flush takes the output path; both are muted on clear/reset.
    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        if (!w_kill) begin
            o_valid = r_vld || w_part;
            o_data  = w_part ? ccff_ljust(r_sr, r_n) : r_byte;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes cfg bytes into the chain head
// with no bubbles while reading the old contents back from the tail.
module ccff_loader
    import ccff_pkg::*;
(
    input  logic                   prog_clk,
    input  logic                   prog_reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CCFF_LEN_W-1:0]  chain_len,
    input  logic [CCFF_BYTE_W-1:0] cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic [CCFF_BYTE_W-1:0] rb_data,
    output logic                   rb_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    ccff_state_e            r_state;
    ccff_state_e            w_next;
    logic [CCFF_LEN_W-1:0]  r_rem;
    logic [CCFF_BYTE_W-1:0] r_buf;
    logic [CCFF_CNT_W-1:0]  r_cnt;
    logic                   r_aborted;

    logic                   w_idle;
    logic                   w_load;
    logic                   w_fin;
    logic                   w_accept;
    logic                   w_abort;
    logic                   w_live;
    logic                   w_shift;
    logic                   w_ready;
    logic                   w_hs;
    logic [CCFF_LEN_W-1:0]  w_rem_nxt;
    logic [CCFF_CNT_W-1:0]  w_take;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_load   = (r_state == ST_LOAD);
    assign w_fin    = (r_state == ST_FIN);
    assign w_accept = w_idle && start && !prog_reset;
    assign w_abort  = abort && !w_idle && !prog_reset;
    assign w_live   = !prog_reset && !w_abort;

    // The buffer refills on the very cycle its last bit leaves.
    assign w_shift = w_load && (r_cnt != '0) && w_live;
    assign w_ready = w_load && w_live
                   && (r_rem > {12'd0, r_cnt})
                   && ((r_cnt == 4'd0)
                       || ((r_cnt == 4'd1) && w_shift));
    assign w_hs    = cfg_valid && w_ready;

    // Bits still owed to the chain once this edge's shift is taken.
    assign w_rem_nxt = r_rem - {15'd0, w_shift};
    assign w_take    = (w_rem_nxt >= 16'd8) ? 4'd8 : w_rem_nxt[3:0];

    assign ccff_head = r_buf[CCFF_BYTE_W-1] && !prog_reset;
    assign aborted   = r_aborted;

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        w_next        = r_state;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (chain_len == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy          = 1'b1;
                cfg_ready     = w_ready;
                ccff_shift_en = w_shift;
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_shift && (r_rem == 16'd1)) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                busy   = 1'b1;
                done   = w_live;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (prog_reset) begin
            busy = 1'b0;
        end
    end

    // Remaining count, shift buffer and sticky abort flag.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_rem     <= '0;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= chain_len;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_rem     <= '0;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b1;
        end else begin
            r_rem <= w_rem_nxt;
            if (w_hs) begin
                r_buf <= cfg_data & ccff_msb_mask(w_take);
                r_cnt <= w_take;
            end else if (w_shift) begin
                r_buf <= r_buf << 1;
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    ccff_rb_deser u_rb (
        .i_clk   (prog_clk),
        .i_rst   (prog_reset),
        .i_clr   (w_abort || w_accept),
        .i_shift (w_shift),
        .i_din   (ccff_tail),
        .i_flush (w_fin && w_live),
        .o_data  (rb_data),
        .o_valid (rb_valid)
    );

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a 16-bit chain model,
// a byte source and per-cycle logging of head/readback/done.
module tb_ccff_loader;

    logic        clk = 1'b0;
    logic        prog_reset;
    logic        start;
    logic        abort;
    logic [15:0] chain_len;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        ccff_head;
    logic        ccff_shift_en;
    logic        ccff_tail;
    logic [7:0]  rb_data;
    logic        rb_valid;
    logic        busy;
    logic        done;
    logic        aborted;

    always #5 clk = ~clk;

    ccff_loader dut (
        .prog_clk      (clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .abort         (abort),
        .chain_len     (chain_len),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    // chain model
    logic [15:0] chain = 16'h0;
    logic [15:0] pre_val = 16'h0;
    logic        pre_go = 1'b0;
    logic [3:0]  tail_idx = 4'd0;

    always @(posedge clk) begin
        if (pre_go)
            chain <= pre_val;
        else if (ccff_shift_en)
            chain <= {chain[14:0], ccff_head};
    end
    assign ccff_tail = chain[tail_idx];

    // byte source
    logic [7:0] src_b [4];
    int         src_n = 0;
    int         src_base = 0;
    logic       src_en = 1'b0;
    int         hs_cnt = 0;

    always @(posedge clk) begin
        if (cfg_valid && cfg_ready)
            hs_cnt <= hs_cnt + 1;
    end

    always_comb begin
        int idx;
        idx = hs_cnt - src_base;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        if (src_en && idx >= 0 && idx < src_n && idx < 4) begin
            cfg_valid = 1'b1;
            cfg_data  = src_b[idx];
        end
    end

    // logs
    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    int          nsh, first_sh, last_sh, nrb, ndone, done_cyc;
    int          nbusy, nrdy;
    logic [31:0] head_log;
    logic [31:0] rb_log;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clr_log();
        nsh = 0; first_sh = 0; last_sh = 0;
        nrb = 0; ndone = 0; done_cyc = 0;
        nbusy = 0; nrdy = 0;
        head_log = '0; rb_log = '0;
    endtask

    // sample at negedge, return at posedge+1
    task automatic cyc();
        #4;
        cyc_n++;
        if (ccff_shift_en) begin
            if (nsh == 0) first_sh = cyc_n;
            last_sh = cyc_n;
            nsh++;
            head_log = {head_log[30:0], ccff_head};
        end
        if (rb_valid) begin
            rb_log = {rb_log[23:0], rb_data};
            nrb++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc_n;
        end
        if (busy) nbusy++;
        if (cfg_ready) nrdy++;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] v, input int len);
        pre_val  = v;
        tail_idx = (len > 0) ? 4'(len - 1) : 4'd0;
        pre_go   = 1'b1;
        cyc();
        pre_go   = 1'b0;
    endtask

    task automatic setsrc(input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic en);
        src_b[0] = b0; src_b[1] = b1;
        src_b[2] = 8'h00; src_b[3] = 8'h00;
        src_n    = n;
        src_base = hs_cnt;
        src_en   = en;
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        chain_len = 16'(len);
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int i;
        i = 0;
        while (ndone == 0 && i < lim) begin
            cyc();
            i++;
        end
        chk("done_seen", ndone, 1);
        cyc();
        cyc();
    endtask

    task automatic wait_shifts(input int k, input int lim);
        int i;
        i = 0;
        while (nsh < k && i < lim) begin
            cyc();
            i++;
        end
        chk("reach_shifts", nsh, k);
    endtask

    typedef struct {
        int          len;
        int          nb;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] pre;
        logic [15:0] head;
        logic [15:0] rb;
        int          nrb;
    } vec_t;

    vec_t vt [6];

    task automatic run_vec(input vec_t v);
        int          st;
        logic [15:0] m;
        m = 16'((32'd1 << v.len) - 32'd1);
        preload(v.pre, v.len);
        clr_log();
        setsrc(v.nb, v.b0, v.b1, 1'b1);
        do_start(v.len);
        st = cyc_n;
        wait_done(60);
        chk("head_seq", head_log[15:0], v.head);
        chk("n_shift", nsh, v.len);
        chk("gapless", (v.len > 0) ? last_sh - first_sh + 1 : 0, v.len);
        chk("rb_bytes", rb_log[15:0], v.rb);
        chk("n_rb", nrb, v.nrb);
        chk("done_at", done_cyc, (v.len > 0) ? last_sh + 1 : st + 1);
        chk("busy_cyc", nbusy, (v.len == 0) ? 1 : v.len + 2);
        chk("chain", chain & m, v.head & m);
        src_en = 1'b0;
    endtask

    initial begin
        vt[0] = '{16, 2, 8'hA5, 8'h3C, 16'hFFFF, 16'hA53C, 16'hFFFF, 2};
        vt[1] = '{11, 2, 8'hF0, 8'hE0, 16'h061D, 16'h0787, 16'hC3A0, 2};
        vt[2] = '{ 8, 1, 8'h5A, 8'h00, 16'h00C6, 16'h005A, 16'h00C6, 1};
        vt[3] = '{ 3, 1, 8'h60, 8'h00, 16'h0006, 16'h0003, 16'h00C0, 1};
        vt[4] = '{ 9, 2, 8'h81, 8'h80, 16'h0155, 16'h0103, 16'hAA80, 2};
        vt[5] = '{ 0, 0, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0};

        prog_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        chain_len  = 16'd0;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        prog_reset = 1'b0;
        #1;
        chk("rst_flags", {cfg_ready, ccff_head, ccff_shift_en, rb_valid,
                          busy, done, aborted}, 0);
        chk("rst_rbdata", rb_data, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // stall: source idle for 5 requested cycles
        preload(16'h0033, 8);
        clr_log();
        setsrc(1, 8'h5A, 8'h00, 1'b0);
        do_start(8);
        for (int i = 0; i < 5; i++) cyc();
        chk("stall_noshift", nsh, 0);
        chk("stall_ready", nrdy, 5);
        src_en = 1'b1;
        wait_done(40);
        chk("stall_nsh", nsh, 8);
        chk("stall_gapless", last_sh - first_sh + 1, 8);
        chk("stall_chain", chain[7:0], 8'h5A);
        chk("stall_rb", rb_log[7:0], 8'h33);
        src_en = 1'b0;

        // abort after 5 shifts
        preload(16'hFFFF, 16);
        clr_log();
        setsrc(2, 8'hA5, 8'h3C, 1'b1);
        do_start(16);
        wait_shifts(5, 20);
        abort = 1'b1;
        #1;
        chk("abort_shift_en", ccff_shift_en, 0);
        chk("abort_ready", cfg_ready, 0);
        cyc();
        abort = 1'b0;
        #1;
        chk("abort_sticky", aborted, 1);
        chk("abort_idle", busy, 0);
        for (int i = 0; i < 5; i++) cyc();
        chk("abort_nodone", ndone, 0);
        chk("abort_nsh", nsh, 5);
        chk("abort_norb", nrb, 0);
        src_en = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("idle_abort_ign", busy, 0);
        clr_log();
        abort = 1'b1;
        do_start(0);
        abort = 1'b0;
        #1;
        chk("start_clr_abort", aborted, 0);
        chk("start_wins", {busy, done}, 2'b11);
        cyc();
        cyc();

        // ignored start while busy
        preload(16'hFFFF, 16);
        clr_log();
        setsrc(2, 8'hA5, 8'h3C, 1'b1);
        do_start(16);
        wait_shifts(3, 20);
        start     = 1'b1;
        chain_len = 16'd2;
        cyc();
        start = 1'b0;
        wait_done(40);
        chk("ign_start_nsh", nsh, 16);
        chk("ign_start_head", head_log[15:0], 16'hA53C);
        chk("ign_start_gap", last_sh - first_sh + 1, 16);
        src_en = 1'b0;

        // reset mid-LOAD
        preload(16'hFFFF, 16);
        clr_log();
        setsrc(2, 8'hA5, 8'h3C, 1'b1);
        do_start(16);
        wait_shifts(4, 20);
        prog_reset = 1'b1;
        #1;
        chk("rst_same_cyc", ccff_shift_en, 0);
        cyc();
        prog_reset = 1'b0;
        src_en = 1'b0;
        #1;
        chk("rst_mid_flags", {cfg_ready, ccff_head, ccff_shift_en, rb_valid,
                              busy, done, aborted}, 0);
        chk("rst_mid_rb", rb_data, 0);
        for (int i = 0; i < 4; i++) cyc();
        chk("rst_nodone", ndone, 0);
        chk("rst_norb", nrb, 0);
        chk("rst_nsh", nsh, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
